// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared constants and helpers for the filter_bank debounce block.
//   DEFAULT_CHANNELS    : default number of debounce channels
//   DEFAULT_STABLE_CNT  : default stable-tick threshold
//   DEFAULT_RESET_LEVEL : default output/synchronizer level after reset
//   cnt_width()         : width of the per-channel stability counter
// -----------------------------------------------------------------------------
package filter_pkg;

  localparam int DEFAULT_CHANNELS    = 8;
  localparam int DEFAULT_STABLE_CNT  = 16;
  localparam bit DEFAULT_RESET_LEVEL = 1'b0;

  // The counter only has to reach STABLE_CNT-1, so clog2(STABLE_CNT) bits are
  // enough; never return zero so the counter stays a legal vector.
  function automatic int cnt_width(input int stable_cnt);
    return (stable_cnt <= 2) ? 1 : $clog2(stable_cnt);
  endfunction

endpackage

// File: rtl/filter_chan.sv
// -----------------------------------------------------------------------------
// filter_chan
// One debounce channel: two-flop synchronizer, stability counter qualified by
// a shared sampling tick, filtered output register and change pulses.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_signal      : raw asynchronous input
//   clock_enable   : sampling tick that qualifies counting
//   out_signal     : debounced level
//   out_signal_en  : one-cycle pulse when out_signal changes
//   rise, fall     : one-cycle pulses on 0->1 / 1->0 output changes
// -----------------------------------------------------------------------------
module filter_chan
  import filter_pkg::*;
#(
  parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
  parameter bit RESET_LEVEL = DEFAULT_RESET_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic in_signal,
  input  logic clock_enable,
  output logic out_signal,
  output logic out_signal_en,
  output logic rise,
  output logic fall
);

  localparam int              CW      = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;
  logic          differs;
  logic          load;

  assign differs = (sync_q2 != out_signal);
  // The last qualifying tick both loads the output and clears the counter,
  // so the counter never wraps.
  assign load    = differs && clock_enable && (cnt == CNT_MAX);

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1       <= RESET_LEVEL;
      sync_q2       <= RESET_LEVEL;
      cnt           <= '0;
      out_signal    <= RESET_LEVEL;
      out_signal_en <= 1'b0;
      rise          <= 1'b0;
      fall          <= 1'b0;
    end else begin
      sync_q1       <= in_signal;
      sync_q2       <= sync_q1;
      out_signal_en <= load;
      rise          <= load &  sync_q2;
      fall          <= load & ~sync_q2;
      if (!differs) begin
        // Agreement on any edge (ticked or not) restarts the stability window.
        cnt <= '0;
      end else if (clock_enable) begin
        if (load) begin
          out_signal <= sync_q2;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/filter_bank.sv
// -----------------------------------------------------------------------------
// filter_bank
// Bank of CHANNELS independent debounce channels sharing one sampling tick.
// Optional feature macro: FILTER_BANK_IRQ_EN adds sticky per-channel status
// bits (set on every output change, write-1-to-clear) and an OR-ed irq.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   in_signal      : raw asynchronous inputs, one per channel
//   clock_enable   : shared sampling tick
//   out_signal     : debounced levels
//   out_signal_en  : one-cycle pulse per output change
//   rise, fall     : one-cycle pulses on 0->1 / 1->0 output changes
//   status_clr     : (FILTER_BANK_IRQ_EN) write-1-to-clear for status
//   status, irq    : (FILTER_BANK_IRQ_EN) sticky change flags and their OR
// -----------------------------------------------------------------------------
module filter_bank
  import filter_pkg::*;
#(
  parameter int CHANNELS    = DEFAULT_CHANNELS,
  parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
  parameter bit RESET_LEVEL = DEFAULT_RESET_LEVEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_signal,
  input  logic                clock_enable,
  output logic [CHANNELS-1:0] out_signal,
  output logic [CHANNELS-1:0] out_signal_en,
  output logic [CHANNELS-1:0] rise,
`ifdef FILTER_BANK_IRQ_EN
  output logic [CHANNELS-1:0] fall,
  input  logic [CHANNELS-1:0] status_clr,
  output logic [CHANNELS-1:0] status,
  output logic                irq
`else
  output logic [CHANNELS-1:0] fall
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    filter_chan #(
      .STABLE_CNT  (STABLE_CNT),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .in_signal     (in_signal[i]),
      .clock_enable  (clock_enable),
      .out_signal    (out_signal[i]),
      .out_signal_en (out_signal_en[i]),
      .rise          (rise[i]),
      .fall          (fall[i])
    );
  end

`ifdef FILTER_BANK_IRQ_EN
  // A new change pulse outranks a clear in the same cycle so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else begin
      status <= (status & ~status_clr) | out_signal_en;
    end
  end

  assign irq = |status;
`endif

endmodule

// File: tb/tb_filter_bank.sv
// -----------------------------------------------------------------------------
// tb_filter_bank
// Self-checking bench for filter_bank with CHANNELS=4, STABLE_CNT=16.
// A reference model tracks, per channel, the count of sampling ticks seen since
// the synchronized input began to disagree with the filtered output.
// -----------------------------------------------------------------------------
module tb_filter_bank;

  localparam int CH = 4;
  localparam int SC = 16;
  localparam bit RL = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] in_signal;
  logic          clock_enable;
  logic [CH-1:0] out_signal;
  logic [CH-1:0] out_signal_en;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] status_clr;
`ifdef FILTER_BANK_IRQ_EN
  logic [CH-1:0] status;
  logic          irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            ce_total;
  int            pending [CH];
  logic [CH-1:0] m_s1, m_s2, m_out, m_en, m_rise, m_fall, m_status;

  filter_bank #(
    .CHANNELS    (CH),
    .STABLE_CNT  (SC),
    .RESET_LEVEL (RL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_signal     (in_signal),
    .clock_enable  (clock_enable),
    .out_signal    (out_signal),
    .out_signal_en (out_signal_en),
    .rise          (rise),
`ifdef FILTER_BANK_IRQ_EN
    .fall          (fall),
    .status_clr    (status_clr),
    .status        (status),
    .irq           (irq)
`else
    .fall          (fall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    ce_total = 0;
    for (int i = 0; i < CH; i++) pending[i] = -1;
    m_s1 = {CH{RL}};
    m_s2 = {CH{RL}};
    m_out = {CH{RL}};
    m_en = '0; m_rise = '0; m_fall = '0; m_status = '0;
  endfunction

  // One clock edge of the specification's behaviour.
  function automatic void model_edge(input logic [CH-1:0] in, input bit ce,
                                     input logic [CH-1:0] clr);
    m_status = (m_status & ~clr) | m_en;
    m_en = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < CH; i++) begin
      if (m_s2[i] == m_out[i]) begin
        pending[i] = -1;
      end else begin
        if (pending[i] < 0) pending[i] = ce_total;
        if (ce_total + int'(ce) - pending[i] >= SC) begin
          m_out[i]  = m_s2[i];
          m_en[i]   = 1'b1;
          m_rise[i] = m_s2[i];
          m_fall[i] = ~m_s2[i];
          pending[i] = -1;
        end
      end
    end
    ce_total += int'(ce);
    m_s2 = m_s1;
    m_s1 = in;
  endfunction

  task automatic compare_all(input string phase);
    check({phase, ".out"},  32'(out_signal),    32'(m_out));
    check({phase, ".en"},   32'(out_signal_en), 32'(m_en));
    check({phase, ".rise"}, 32'(rise),          32'(m_rise));
    check({phase, ".fall"}, 32'(fall),          32'(m_fall));
`ifdef FILTER_BANK_IRQ_EN
    check({phase, ".status"}, 32'(status), 32'(m_status));
    check({phase, ".irq"},    32'(irq),    32'(|m_status));
`endif
  endtask

  // Drive inputs, let one edge pass, update the model, sample 1 ns later.
  task automatic tick(input logic [CH-1:0] in, input bit ce, input logic [CH-1:0] clr);
    in_signal    = in;
    clock_enable = ce;
    status_clr   = clr;
    @(posedge clk);
    model_edge(in, ce, clr);
    #1;
    compare_all("tick");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    #1;
    check("rst.out_const", 32'(out_signal), 32'({CH{RL}}));
    check("rst.pulses",    32'({out_signal_en, rise, fall}), 32'(0));
    rst = 1'b0;
  endtask

  initial begin
    int found;
    logic any_pulse;
    logic [CH-1:0] cur;

    rst = 1'b1; in_signal = '0; clock_enable = 1'b0; status_clr = '0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset.out",    32'(out_signal), 32'({CH{RL}}));
    check("reset.pulses", 32'({out_signal_en, rise, fall}), 32'(0));
    rst = 1'b0;

    // Clean step on channel 0: change visible after edge k+17 (18th tick).
    found = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(4'b0001, 1'b1, '0);
      if (out_signal[0] === 1'b1) begin found = t; break; end
    end
    check("step0.latency", 32'(found), 32'd18);
    check("step0.en_rise", 32'({out_signal_en[0], rise[0], fall[0]}), 32'b110);
    tick(4'b0001, 1'b1, '0);
    check("step0.pulse_one_cycle", 32'({out_signal_en[0], rise[0]}), 32'b00);

    // Short glitch on channel 1: no output change, no pulse.
    any_pulse = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick((t < 10) ? 4'b0011 : 4'b0001, 1'b1, '0);
      any_pulse |= out_signal_en[1] | rise[1] | fall[1] | out_signal[1];
    end
    check("glitch1.quiet", 32'(any_pulse), 32'd0);

    // Channel 2 step with a tick every fourth cycle: 16th ticked edge (t=64).
    found = 0;
    for (int t = 1; t <= 100; t++) begin
      tick(4'b0101, (t % 4) == 0, '0);
      if (out_signal[2] === 1'b1) begin found = t; break; end
    end
    check("slow2.latency", 32'(found), 32'd64);

    // Channel 3: reset after 8 counted ticks discards the partial count.
    for (int t = 1; t <= 10; t++) tick(4'b1101, 1'b1, '0);
    check("mid3.no_change", 32'(out_signal[3]), 32'd0);
    do_reset();
    found = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(4'b1101, 1'b1, '0);
      if (out_signal[3] === 1'b1) begin found = t; break; end
    end
    check("mid3.full_restart", 32'(found), 32'd18);

    // All channels high, then a simultaneous 1->0 step.
    found = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(4'b1111, 1'b1, '0);
      if (out_signal === 4'b1111) begin found = t; break; end
    end
    check("all.high_reached", 32'(found != 0), 32'd1);
    found = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(4'b0000, 1'b1, '0);
      if (out_signal === 4'b0000) begin found = t; break; end
    end
    check("all.fall_latency", 32'(found), 32'd18);
    check("all.fall_vec", 32'({fall, rise}), 32'({4'b1111, 4'b0000}));

    // Randomized run: rarely toggling inputs, irregular ticks, random clears.
    cur = '0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 24) == 0) cur[i] = ~cur[i];
      tick(cur, $urandom_range(0, 3) != 0, CH'($urandom_range(0, 15)));
    end

`ifdef FILTER_BANK_IRQ_EN
    do_reset();
    found = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(4'b0001, 1'b1, '0);
      if (out_signal_en[0] === 1'b1) begin found = t; break; end
    end
    check("irq.event_seen", 32'(found != 0), 32'd1);
    tick(4'b0001, 1'b1, '0);
    check("irq.status_set", 32'({status, irq}), 32'({4'b0001, 1'b1}));
    found = 0;
    for (int t = 1; t <= 40; t++) begin
      tick(4'b0000, 1'b1, '0);
      if (out_signal_en[0] === 1'b1) begin found = t; break; end
    end
    check("irq.second_event", 32'(found != 0), 32'd1);
    tick(4'b0000, 1'b1, 4'b0001);
    check("irq.set_wins", 32'({status, irq}), 32'({4'b0001, 1'b1}));
    tick(4'b0000, 1'b1, 4'b0001);
    check("irq.cleared", 32'({status, irq}), 32'({4'b0000, 1'b0}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
